regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the ID-stage register file.
- Two write ports and two read ports, with optional same-cycle write-to-read bypass.
- Hardwired-zero register 0, made optional.
- Adds a hardware clear sequencer and a per-register pending-write scoreboard for hazard detection.
- Sits in ID: read ports feed the A/B operand latches; write ports are driven from WB (port 0) and a late-result path (port 1).

Parameters:
- DATA_W, 32, register data width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never marked pending
- BYPASS, 1, 1 = read returns same-cycle write data; 0 = read returns stored value only

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- clr_req  in  1  request full-array clear sweep; sampled in IDLE only
- busy  out  1  1 while clear sweep runs
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_W  write address, port 0
- wdata0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (priority port)
- waddr1  in  ADDR_W  write address, port 1
- wdata1  in  DATA_W  write data, port 1
- raddr0  in  ADDR_W  read address A
- rdata0  out  DATA_W  read data A (combinational)
- raddr1  in  ADDR_W  read address B
- rdata1  out  DATA_W  read data B (combinational)
- set_pend  in  1  mark register set_addr as awaiting a write
- set_addr  in  ADDR_W  register to mark pending
- pend0  out  1  pending bit of raddr0 (combinational)
- pend1  out  1  pending bit of raddr1 (combinational)

Behaviour:

Reset:
- rst asserted asynchronously forces state=CLEAR, clr_cnt=0, and all pending bits 0.
- Outputs during and after reset: busy=1, rdata0/rdata1=0, pend0/pend1=0.
- The storage array is not reset directly; the sweep zeroes it.

State machine:
- CLEAR:
  - Each cycle writes 0 to entry clr_cnt, then clr_cnt+1.
  - Takes exactly 2**ADDR_W cycles (32 at default).
  - Leaves CLEAR for IDLE on the edge that writes entry 2**ADDR_W-1.
  - busy=1 for the whole of CLEAR; busy=0 in IDLE.
- IDLE:
  - clr_req=1 at a posedge moves to CLEAR with clr_cnt=0 and clears all pending bits.
  - clr_req is ignored while in CLEAR.
- rst asserted mid-sweep restarts the sweep at clr_cnt=0.

During CLEAR:
- we0, we1 and set_pend are ignored.
- rdata0/rdata1 are forced to 0 and pend0/pend1 are forced to 0.

Writes (IDLE only), on posedge:
- we0 writes wdata0 to waddr0; we1 writes wdata1 to waddr1.
- Both ports to the same address: port 1 data is stored.
- ZERO_REG=1 with address 0: the write is dropped.

Reads:
- rdata = stored[raddr], combinational.
- BYPASS=1: if we1 && waddr1==raddr, return wdata1; else if we0 && waddr0==raddr, return wdata0; else stored.
- ZERO_REG=1 and raddr==0: returns 0 regardless of bypass.

Scoreboard:
- Pending bits update on posedge.
- A write on either port to address X clears pend[X].
- set_pend sets pend[set_addr]. If set_pend targets the same X as a write in the same cycle, set wins (new producer issued).
- ZERO_REG=1 with set_addr==0: ignored.
- pend outputs reflect registered state only; same-cycle writes do not bypass into pend.

Widths:
- Addresses compare over the full ADDR_W.
- clr_cnt is ADDR_W+1 bits wide, or wraps with a terminal-count flag; it must not alias.

Test Plan:
1. Reset sweep: pulse rst, hold idle. Require busy=1 for exactly 32 cycles, then 0; rdata0=0 for every raddr0 0..31 after busy falls.
2. Write/read and bypass: write 0xDEADBEEF to r5 via port 0.
   - Same cycle, raddr0=5: rdata0=0xDEADBEEF (BYPASS=1).
   - Next cycle: stored value 0xDEADBEEF.
   - With BYPASS=0, same-cycle read gives the old value 0.
3. Write conflict and zero register:
   - we0 and we1 both to r7 with 0x11111111 / 0x22222222: r7 reads 0x22222222.
   - Write 0xFFFFFFFF to r0: r0 reads 0, including same-cycle bypass.
4. Scoreboard:
   - set_pend r9: next cycle pend0=1 with raddr0=9.
   - Write r9: pend0=0 the cycle after.
   - Simultaneous set_pend r9 and write r9: pend stays 1.
   - set_pend r0: pend stays 0.
5. clr_req mid-operation:
   - Fill r1..r3 with 1,2,3, then set r4 pending. Pulse clr_req.
   - Writes during busy are dropped and pend outputs read 0.
   - After 32 cycles, r1..r3 read 0 and pend[4]=0.
6. Reset mid-sweep: assert rst at sweep cycle 10. Require busy to stay 1 for 32 full cycles after rst deasserts, and all entries to read 0 afterwards.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two write ports, two read ports, the clear request/busy pair,
// and the pending-write scoreboard. master = ID/WB pipeline side, slave = register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              clr_req;
  logic              busy;
  logic              we0;
  logic [ADDR_W-1:0] waddr0;
  logic [DATA_W-1:0] wdata0;
  logic              we1;
  logic [ADDR_W-1:0] waddr1;
  logic [DATA_W-1:0] wdata1;
  logic [ADDR_W-1:0] raddr0;
  logic [DATA_W-1:0] rdata0;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              set_pend;
  logic [ADDR_W-1:0] set_addr;
  logic              pend0;
  logic              pend1;

  modport master (
    output clr_req, we0, waddr0, wdata0, we1, waddr1, wdata1,
           raddr0, raddr1, set_pend, set_addr,
    input  busy, rdata0, rdata1, pend0, pend1
  );

  modport slave (
    input  clr_req, we0, waddr0, wdata0, we1, waddr1, wdata1,
           raddr0, raddr1, set_pend, set_addr,
    output busy, rdata0, rdata1, pend0, pend1
  );
endinterface

// File: rtl/regfile_mp.sv
// Two-write/two-read register file with optional bypass and hardwired zero register,
// a hardware clear sweep after reset or on request, and a per-register pending-write scoreboard.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W:0]   clr_cnt_reg;
  logic [ADDR_W:0]   clr_cnt_next;
  logic              clear_all;
  logic              idle;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend_vec;

  logic              wr0_ok;
  logic              wr1_ok;
  logic              set_ok;

  // ---------------- clear sequencer ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    clear_all    = 1'b0;
    case (state_reg)
      CLEAR: begin
        // Full-width compare on the extra-bit counter so the last entry cannot alias entry 0.
        if (clr_cnt_reg == (ADDR_W + 1)'(DEPTH - 1)) begin
          state_next   = IDLE;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
        end
      end
      IDLE: begin
        if (bus.clr_req) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
          clear_all    = 1'b1;
        end
      end
      default: begin
        state_next   = CLEAR;
        clr_cnt_next = '0;
      end
    endcase
  end

  assign idle     = (state_reg == IDLE);
  assign bus.busy = ~idle;

  // ---------------- write qualification ----------------
  assign wr0_ok = idle && bus.we0 && !(ZERO_REG && (bus.waddr0 == '0));
  assign wr1_ok = idle && bus.we1 && !(ZERO_REG && (bus.waddr1 == '0));
  assign set_ok = idle && bus.set_pend && !(ZERO_REG && (bus.set_addr == '0));

  // ---------------- storage ----------------
  // Port 1 is assigned last so it wins a same-address conflict.
  always_ff @(posedge clk) begin
    if (!idle) begin
      mem[clr_cnt_reg[ADDR_W-1:0]] <= '0;
    end else begin
      if (wr0_ok) mem[bus.waddr0] <= bus.wdata0;
      if (wr1_ok) mem[bus.waddr1] <= bus.wdata1;
    end
  end

  // ---------------- pending scoreboard ----------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
      logic pend_reg;
      logic set_hit;
      logic wr_hit;

      assign set_hit = set_ok && (bus.set_addr == ADDR_W'(gi));
      assign wr_hit  = (wr0_ok && (bus.waddr0 == ADDR_W'(gi))) ||
                       (wr1_ok && (bus.waddr1 == ADDR_W'(gi)));

      // A new producer issued in the same cycle as the old one retires keeps the bit set.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pend_reg <= 1'b0;
        end else if (clear_all) begin
          pend_reg <= 1'b0;
        end else if (set_hit) begin
          pend_reg <= 1'b1;
        end else if (wr_hit) begin
          pend_reg <= 1'b0;
        end
      end

      assign pend_vec[gi] = pend_reg;
    end
  endgenerate

  // ---------------- read ports ----------------
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    val = stored;
    if (BYPASS) begin
      if (bus.we1 && (bus.waddr1 == ra))      val = bus.wdata1;
      else if (bus.we0 && (bus.waddr0 == ra)) val = bus.wdata0;
    end
    if (!idle || (ZERO_REG && (ra == '0))) val = '0;
    return val;
  endfunction

  assign bus.rdata0 = read_port(bus.raddr0, mem[bus.raddr0]);
  assign bus.rdata1 = read_port(bus.raddr1, mem[bus.raddr1]);

  assign bus.pend0 = idle && pend_vec[bus.raddr0];
  assign bus.pend1 = idle && pend_vec[bus.raddr1];
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a BYPASS=1 instance and a BYPASS=0 twin driven with identical stimulus.
module tb_regfile_mp;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cnt;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  assign bus_b.clr_req  = bus_a.clr_req;
  assign bus_b.we0      = bus_a.we0;
  assign bus_b.waddr0   = bus_a.waddr0;
  assign bus_b.wdata0   = bus_a.wdata0;
  assign bus_b.we1      = bus_a.we1;
  assign bus_b.waddr1   = bus_a.waddr1;
  assign bus_b.wdata1   = bus_a.wdata1;
  assign bus_b.raddr0   = bus_a.raddr0;
  assign bus_b.raddr1   = bus_a.raddr1;
  assign bus_b.set_pend = bus_a.set_pend;
  assign bus_b.set_addr = bus_a.set_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.clr_req  = 1'b0;
    bus_a.we0      = 1'b0;
    bus_a.waddr0   = '0;
    bus_a.wdata0   = '0;
    bus_a.we1      = 1'b0;
    bus_a.waddr1   = '0;
    bus_a.wdata1   = '0;
    bus_a.set_pend = 1'b0;
    bus_a.set_addr = '0;
  endtask

  // Counts cycles busy stays high starting from the current sample point.
  task automatic count_busy(output int n);
    n = 0;
    while (bus_a.busy && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus_a.raddr0 = 5'(i);
      #1;
      chk(tag, bus_a.rdata0, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    bus_a.raddr0 = 5'd0;
    bus_a.raddr1 = 5'd0;

    // 1. reset state and sweep length
    step(); step();
    chk("rst_busy", {31'b0, bus_a.busy}, 32'h1);
    chk("rst_rdata0", bus_a.rdata0, 32'h0);
    chk("rst_rdata1", bus_a.rdata1, 32'h0);
    chk("rst_pend0", {31'b0, bus_a.pend0}, 32'h0);
    rst = 1'b0;
    count_busy(cnt);
    chk("sweep_len", cnt, 32);
    chk("sweep_busy_low", {31'b0, bus_a.busy}, 32'h0);
    check_all_zero("sweep_zero");
    $display("step1 reset sweep busy_cycles=%0d", cnt);

    // 2. write/read and bypass on r5
    bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd5; bus_a.wdata0 = 32'hDEADBEEF; bus_a.raddr0 = 5'd5;
    #1;
    chk("bypass_on", bus_a.rdata0, 32'hDEADBEEF);
    chk("bypass_off", bus_b.rdata0, 32'h0);
    step();
    idle_inputs();
    #1;
    chk("stored_r5", bus_a.rdata0, 32'hDEADBEEF);
    chk("stored_r5_nobyp", bus_b.rdata0, 32'hDEADBEEF);
    $display("step2 write r5 rdata0=%h", bus_a.rdata0);

    // 3. write conflict on r7, then writes to r0
    bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd7; bus_a.wdata0 = 32'h11111111;
    bus_a.we1 = 1'b1; bus_a.waddr1 = 5'd7; bus_a.wdata1 = 32'h22222222;
    bus_a.raddr0 = 5'd7; bus_a.raddr1 = 5'd7;
    #1;
    chk("conflict_bypass", bus_a.rdata0, 32'h22222222);
    step();
    idle_inputs();
    #1;
    chk("conflict_r7_a", bus_a.rdata0, 32'h22222222);
    chk("conflict_r7_b", bus_a.rdata1, 32'h22222222);
    bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd0; bus_a.wdata0 = 32'hFFFFFFFF;
    bus_a.we1 = 1'b1; bus_a.waddr1 = 5'd0; bus_a.wdata1 = 32'hFFFFFFFF;
    bus_a.raddr0 = 5'd0; bus_a.raddr1 = 5'd0;
    #1;
    chk("r0_bypass", bus_a.rdata0, 32'h0);
    step();
    idle_inputs();
    #1;
    chk("r0_stored", bus_a.rdata0, 32'h0);
    chk("r0_stored_nobyp", bus_b.rdata1, 32'h0);
    $display("step3 conflict r7=%h r0=%h", 32'h22222222, bus_a.rdata0);

    // 4. scoreboard
    bus_a.set_pend = 1'b1; bus_a.set_addr = 5'd9; bus_a.raddr0 = 5'd9; bus_a.raddr1 = 5'd10;
    #1;
    chk("pend_no_bypass", {31'b0, bus_a.pend0}, 32'h0);
    step();
    idle_inputs();
    #1;
    chk("pend_set_r9", {31'b0, bus_a.pend0}, 32'h1);
    chk("pend_r10_clear", {31'b0, bus_a.pend1}, 32'h0);
    bus_a.we1 = 1'b1; bus_a.waddr1 = 5'd9; bus_a.wdata1 = 32'h00000099;
    step();
    idle_inputs();
    #1;
    chk("pend_cleared_r9", {31'b0, bus_a.pend0}, 32'h0);
    bus_a.set_pend = 1'b1; bus_a.set_addr = 5'd9;
    bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd9; bus_a.wdata0 = 32'h00000009;
    step();
    idle_inputs();
    #1;
    chk("pend_set_wins", {31'b0, bus_a.pend0}, 32'h1);
    bus_a.set_pend = 1'b1; bus_a.set_addr = 5'd0; bus_a.raddr1 = 5'd0;
    step();
    idle_inputs();
    #1;
    chk("pend_r0_ignored", {31'b0, bus_a.pend1}, 32'h0);
    $display("step4 scoreboard pend9=%0b pend0=%0b", bus_a.pend0, bus_a.pend1);

    // 5. clr_req mid-operation
    for (int i = 1; i <= 3; i++) begin
      bus_a.we0 = 1'b1; bus_a.waddr0 = 5'(i); bus_a.wdata0 = 32'(i);
      step();
    end
    idle_inputs();
    bus_a.set_pend = 1'b1; bus_a.set_addr = 5'd4;
    step();
    idle_inputs();
    bus_a.raddr0 = 5'd2; bus_a.raddr1 = 5'd4;
    #1;
    chk("fill_r2", bus_a.rdata0, 32'h2);
    chk("pend_r4_set", {31'b0, bus_a.pend1}, 32'h1);
    bus_a.clr_req = 1'b1;
    step();
    bus_a.clr_req = 1'b0;
    bus_a.raddr0 = 5'd1;
    bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd10; bus_a.wdata0 = 32'h0000ABCD;
    bus_a.set_pend = 1'b1; bus_a.set_addr = 5'd11;
    #1;
    chk("clr_busy", {31'b0, bus_a.busy}, 32'h1);
    chk("clr_pend_forced", {31'b0, bus_a.pend1}, 32'h0);
    chk("clr_rdata_forced", bus_a.rdata0, 32'h0);
    count_busy(cnt);
    idle_inputs();
    chk("clr_len", cnt, 32);
    for (int i = 1; i <= 3; i++) begin
      bus_a.raddr0 = 5'(i);
      #1;
      chk("clr_r1_3", bus_a.rdata0, 32'h0);
    end
    bus_a.raddr0 = 5'd10; bus_a.raddr1 = 5'd4;
    #1;
    chk("clr_drop_write", bus_a.rdata0, 32'h0);
    chk("clr_pend_r4", {31'b0, bus_a.pend1}, 32'h0);
    bus_a.raddr1 = 5'd11;
    #1;
    chk("clr_drop_setpend", {31'b0, bus_a.pend1}, 32'h0);
    $display("step5 clr_req sweep busy_cycles=%0d", cnt);

    // 6. reset at sweep cycle 10
    bus_a.we0 = 1'b1; bus_a.waddr0 = 5'd25; bus_a.wdata0 = 32'h55555555;
    step();
    idle_inputs();
    bus_a.raddr0 = 5'd25;
    #1;
    chk("pre_r25", bus_a.rdata0, 32'h55555555);
    bus_a.clr_req = 1'b1;
    step();
    bus_a.clr_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", {31'b0, bus_a.busy}, 32'h1);
    step();
    rst = 1'b0;
    count_busy(cnt);
    chk("rst_mid_len", cnt, 32);
    check_all_zero("rst_mid_zero");
    $display("step6 reset mid-sweep busy_cycles=%0d", cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
